// File: rtl/pe_pkg.sv
// Shared types and width helpers for the SAD processing-element column.
package pe_pkg;

  typedef enum logic [1:0] {
    SHIFT_DOWN = 2'd0,
    SHIFT_UP   = 2'd1,
    LOAD_RIGHT = 2'd2,
    CLEAR      = 2'd3
  } spr_sel_e;

  // A sum of SUB_DIM unsigned pixels needs log2(SUB_DIM) extra bits.
  function automatic int unsigned sub_sad_w(int unsigned pixel_w, int unsigned sub_dim);
    return pixel_w + $clog2(sub_dim);
  endfunction

  function automatic int unsigned col_sad_w(int unsigned pixel_w, int unsigned macro_dim);
    return pixel_w + $clog2(macro_dim);
  endfunction

endpackage

// File: rtl/pe_cell.sv
// One row of the column: search-pixel register with 4:1 update select,
// current-pixel register, and their absolute difference.
module pe_cell
  import pe_pkg::*;
#(
  parameter int unsigned PIXEL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_spr_i,
  input  logic               en_cpr_i,
  input  logic [1:0]         sel_i,
  input  logic [PIXEL_W-1:0] down_i,
  input  logic [PIXEL_W-1:0] up_i,
  input  logic [PIXEL_W-1:0] right_i,
  input  logic [PIXEL_W-1:0] cpr_i,
  output logic [PIXEL_W-1:0] spr_o,
  output logic [PIXEL_W-1:0] cpr_o,
  output logic [PIXEL_W-1:0] ad_o
);

  logic [PIXEL_W-1:0] spr_q, spr_d;
  logic [PIXEL_W-1:0] cpr_q, cpr_d;

  always_comb begin
    spr_d = spr_q;
    if (en_spr_i) begin
      unique case (spr_sel_e'(sel_i))
        SHIFT_DOWN: spr_d = down_i;
        SHIFT_UP:   spr_d = up_i;
        LOAD_RIGHT: spr_d = right_i;
        CLEAR:      spr_d = '0;
      endcase
    end
    cpr_d = en_cpr_i ? cpr_i : cpr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spr_q <= '0;
      cpr_q <= '0;
    end else begin
      spr_q <= spr_d;
      cpr_q <= cpr_d;
    end
  end

  assign spr_o = spr_q;
  assign cpr_o = cpr_q;
  assign ad_o  = (spr_q >= cpr_q) ? (spr_q - cpr_q) : (cpr_q - spr_q);

endmodule

// File: rtl/pe_sad_col.sv
// Column of motion-estimation PEs with a two-stage registered SAD tree
// producing per-sub-block and whole-column sums two cycles after a sample.
module pe_sad_col
  import pe_pkg::*;
#(
  parameter int unsigned MACRO_DIM = 16,
  parameter int unsigned PIXEL_W   = 8,
  parameter int unsigned SUB_DIM   = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   en_spr,
  input  logic                                                   en_cpr,
  input  logic [1:0]                                             sel,
  input  logic [PIXEL_W-1:0]                                     pixel_spr_in,
  input  logic [PIXEL_W-1:0]                                     pixel_spr_bot_in,
  input  logic [MACRO_DIM*PIXEL_W-1:0]                           pixel_spr_right_in,
  input  logic [PIXEL_W-1:0]                                     pixel_cpr_in,
  input  logic                                                   sample_valid,
  output logic [PIXEL_W-1:0]                                     pixel_spr_out,
  output logic [PIXEL_W-1:0]                                     pixel_spr_top_out,
  output logic [PIXEL_W-1:0]                                     pixel_cpr_out,
  output logic [MACRO_DIM*PIXEL_W-1:0]                           pixel_spr_taps,
  output logic [(MACRO_DIM/SUB_DIM)*sub_sad_w(PIXEL_W, SUB_DIM)-1:0] sub_sad,
  output logic [col_sad_w(PIXEL_W, MACRO_DIM)-1:0]               col_sad,
  output logic                                                   out_valid
);

  localparam int unsigned NumSub = MACRO_DIM / SUB_DIM;
  localparam int unsigned SubW   = sub_sad_w(PIXEL_W, SUB_DIM);
  localparam int unsigned ColW   = col_sad_w(PIXEL_W, MACRO_DIM);

  if (MACRO_DIM % SUB_DIM != 0) begin : g_bad_macro_dim
    $error("MACRO_DIM must be a multiple of SUB_DIM");
  end
  if ((SUB_DIM < 2) || ((SUB_DIM & (SUB_DIM - 1)) != 0)) begin : g_bad_sub_dim
    $error("SUB_DIM must be a power of two and at least 2");
  end

  logic [PIXEL_W-1:0] spr [MACRO_DIM];
  logic [PIXEL_W-1:0] cpr [MACRO_DIM];
  logic [PIXEL_W-1:0] ad  [MACRO_DIM];

  for (genvar i = 0; i < MACRO_DIM; i++) begin : g_row
    logic [PIXEL_W-1:0] down_in, up_in, cpr_in;

    if (i == 0) begin : g_first
      assign down_in = pixel_spr_in;
      assign cpr_in  = pixel_cpr_in;
    end else begin : g_chain
      assign down_in = spr[i-1];
      assign cpr_in  = cpr[i-1];
    end

    if (i == MACRO_DIM - 1) begin : g_last
      assign up_in = pixel_spr_bot_in;
    end else begin : g_up
      assign up_in = spr[i+1];
    end

    pe_cell #(
      .PIXEL_W (PIXEL_W)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_spr_i (en_spr),
      .en_cpr_i (en_cpr),
      .sel_i    (sel),
      .down_i   (down_in),
      .up_i     (up_in),
      .right_i  (pixel_spr_right_in[i*PIXEL_W +: PIXEL_W]),
      .cpr_i    (cpr_in),
      .spr_o    (spr[i]),
      .cpr_o    (cpr[i]),
      .ad_o     (ad[i])
    );

    assign pixel_spr_taps[i*PIXEL_W +: PIXEL_W] = spr[i];
  end

  assign pixel_spr_out     = spr[MACRO_DIM-1];
  assign pixel_spr_top_out = spr[0];
  assign pixel_cpr_out     = cpr[MACRO_DIM-1];

  logic [SubW-1:0] s1_q      [NumSub];
  logic [SubW-1:0] s1_d      [NumSub];
  logic [SubW-1:0] sub_sad_q [NumSub];
  logic [ColW-1:0] col_sad_q, col_sad_d;
  logic            v1_q, out_valid_q;

  always_comb begin
    for (int k = 0; k < NumSub; k++) begin
      s1_d[k] = '0;
      for (int j = 0; j < SUB_DIM; j++) begin
        s1_d[k] = s1_d[k] + SubW'(ad[k*SUB_DIM + j]);
      end
    end
  end

  always_comb begin
    col_sad_d = '0;
    for (int k = 0; k < NumSub; k++) begin
      col_sad_d = col_sad_d + ColW'(s1_q[k]);
    end
  end

  // Data stages run every cycle; only the valid chain decides what is emitted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NumSub; k++) begin
        s1_q[k]      <= '0;
        sub_sad_q[k] <= '0;
      end
      col_sad_q   <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NumSub; k++) begin
        s1_q[k]      <= s1_d[k];
        sub_sad_q[k] <= s1_q[k];
      end
      col_sad_q   <= col_sad_d;
      v1_q        <= sample_valid;
      out_valid_q <= v1_q;
    end
  end

  for (genvar k = 0; k < NumSub; k++) begin : g_sub_out
    assign sub_sad[k*SubW +: SubW] = sub_sad_q[k];
  end

  assign col_sad   = col_sad_q;
  assign out_valid = out_valid_q;

endmodule
